// File: rtl/ram32k_arbiter.sv
// Two-requester arbiter/sequencer sharing one 32K x 16 RAM (A = CPU data, B = loader/DMA).
// Latency: ack is combinational in the access cycle; read data + rvalid one cycle after a read ack.
// Backpressure: a requester holds req and fields until ack; no ack means the request simply waits.

// 32K x 16 single-port RAM built from two 16K banks; registered read, write-first on next cycle.
// Latency: one cycle from address to rdata.
// Backpressure: none, accepts an access every cycle.
module ram32k (
  input  logic        clock,
  input  logic [14:0] address,
  input  logic [15:0] wdata,
  input  logic        load,
  output logic [15:0] rdata
);

  logic [15:0] lo_mem [0:16383];
  logic [15:0] hi_mem [0:16383];
  logic [15:0] lo_q;
  logic [15:0] hi_q;
  logic        bank_q;

  always_ff @(posedge clock) begin
    if (load && !address[14]) lo_mem[address[13:0]] <= wdata;
    if (load &&  address[14]) hi_mem[address[13:0]] <= wdata;
    lo_q   <= lo_mem[address[13:0]];
    hi_q   <= hi_mem[address[13:0]];
    bank_q <= address[14];
  end

  assign rdata = bank_q ? hi_q : lo_q;

endmodule

// Arbiter: at most one ack per cycle, round-robin or A-priority with a B starvation guard.
// Latency: ack same cycle as grant; rvalid/rdata one cycle after a read ack.
// Backpressure: the losing requester keeps req high and is served in a later cycle.
module ram32k_arbiter #(
  parameter int FIXED_PRIORITY = 0,
  parameter int MAX_WAIT       = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [14:0] a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_ack,
  output logic        a_rvalid,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [14:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_ack,
  output logic        b_rvalid,
  output logic [15:0] b_rdata
);

  localparam logic [7:0] MAX_WAIT_L = 8'(MAX_WAIT);

  logic        last_grant_b;
  logic [7:0]  wait_b;
  logic [1:0]  rvalid_tag;
  logic [14:0] addr_q;
  logic        a_pref;
  logic        grant_a;
  logic        grant_b;
  logic [14:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_load;
  logic [15:0] ram_rdata;

  // On a conflict A wins when B went last (round-robin) or B has not waited too long.
  always_comb begin
    a_pref = 1'b0;
    if (FIXED_PRIORITY != 0) a_pref = (wait_b < MAX_WAIT_L);
    else                     a_pref = last_grant_b;
  end

  // Reset forces both acks low immediately, so no access reaches the RAM while held.
  assign grant_a = reset_n & a_req & (~b_req | a_pref);
  assign grant_b = reset_n & b_req & ~grant_a;
  assign a_ack   = grant_a;
  assign b_ack   = grant_b;

  always_comb begin
    ram_addr  = addr_q;
    ram_wdata = a_wdata;
    ram_load  = 1'b0;
    if (grant_a) begin
      ram_addr  = a_addr;
      ram_wdata = a_wdata;
      ram_load  = a_we;
    end else if (grant_b) begin
      ram_addr  = b_addr;
      ram_wdata = b_wdata;
      ram_load  = b_we;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_b <= 1'b1;
      wait_b       <= 8'd0;
      rvalid_tag   <= 2'b00;
      addr_q       <= 15'd0;
    end else begin
      if (grant_a)      last_grant_b <= 1'b0;
      else if (grant_b) last_grant_b <= 1'b1;

      if (!b_req || grant_b)    wait_b <= 8'd0;
      else if (wait_b != 8'hFF) wait_b <= wait_b + 8'd1;

      rvalid_tag <= {grant_b & ~b_we, grant_a & ~a_we};

      if (grant_a || grant_b) addr_q <= ram_addr;
    end
  end

  ram32k u_ram (
    .clock   (clock),
    .address (ram_addr),
    .wdata   (ram_wdata),
    .load    (ram_load),
    .rdata   (ram_rdata)
  );

  assign a_rvalid = rvalid_tag[0];
  assign b_rvalid = rvalid_tag[1];
  assign a_rdata  = rvalid_tag[0] ? ram_rdata : 16'd0;
  assign b_rdata  = rvalid_tag[1] ? ram_rdata : 16'd0;

endmodule

// File: tb/tb_ram32k_arbiter.sv
// Directed bench: round-robin instance for data paths and reset, fixed-priority instance for the starvation guard.
module tb_ram32k_arbiter;

  logic        clock;
  logic        reset_n;
  logic        a_req, a_we, b_req, b_we;
  logic [14:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ack, a_rvalid, b_ack, b_rvalid;
  logic [15:0] a_rdata, b_rdata;

  logic        f_a_req, f_b_req;
  logic        f_a_ack, f_a_rvalid, f_b_ack, f_b_rvalid;
  logic [15:0] f_a_rdata, f_b_rdata;

  int checks = 0;
  int errors = 0;

  ram32k_arbiter #(.FIXED_PRIORITY(0), .MAX_WAIT(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata)
  );

  ram32k_arbiter #(.FIXED_PRIORITY(1), .MAX_WAIT(3)) dut_fp (
    .clock(clock), .reset_n(reset_n),
    .a_req(f_a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(f_a_ack), .a_rvalid(f_a_rvalid), .a_rdata(f_a_rdata),
    .b_req(f_b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(f_b_ack), .b_rvalid(f_b_rvalid), .b_rdata(f_b_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  logic exp_fb [0:3];
  logic [7:0] exp_wait [0:3];

  initial begin
    reset_n = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 15'h0010; a_wdata = 16'h1111;
    b_req = 1'b1; b_we = 1'b1; b_addr = 15'h0010; b_wdata = 16'h2222;
    f_a_req = 1'b0; f_b_req = 1'b0;
    exp_fb   = '{1'b0, 1'b0, 1'b0, 1'b1};
    exp_wait = '{8'd0, 8'd1, 8'd2, 8'd3};

    // Reset state: requests present but nothing acked.
    sample();
    check("rst_a_ack", a_ack, 0);
    check("rst_b_ack", b_ack, 0);
    check("rst_a_rvalid", a_rvalid, 0);
    check("rst_b_rvalid", b_rvalid, 0);
    check("rst_wait_b", dut_fp.wait_b, 0);
    tick();
    a_req = 1'b0; b_req = 1'b0;
    reset_n = 1'b1;

    // Test 1: A writes then reads 0x0010.
    tick();
    a_req = 1'b1; a_we = 1'b1; a_addr = 15'h0010; a_wdata = 16'hBEEF;
    sample();
    check("t1_wr_a_ack", a_ack, 1);
    check("t1_wr_b_ack", b_ack, 0);
    tick();
    a_we = 1'b0;
    sample();
    check("t1_rd_a_ack", a_ack, 1);
    check("t1_no_rvalid_after_wr", a_rvalid, 0);
    tick();
    a_req = 1'b0;
    sample();
    check("t1_a_rvalid", a_rvalid, 1);
    check("t1_a_rdata", a_rdata, 16'hBEEF);
    check("t1_b_rvalid", b_rvalid, 0);
    check("t1_a_ack_drop", a_ack, 0);

    // Test 2: B writes both banks then reads back-to-back.
    tick();
    b_req = 1'b1; b_we = 1'b1; b_addr = 15'h4001; b_wdata = 16'h1234;
    sample();
    check("t2_wr_hi_ack", b_ack, 1);
    tick();
    b_addr = 15'h0001; b_wdata = 16'h5678;
    sample();
    check("t2_wr_lo_ack", b_ack, 1);
    tick();
    b_we = 1'b0; b_addr = 15'h4001;
    sample();
    check("t2_rd_hi_ack", b_ack, 1);
    tick();
    b_addr = 15'h0001;
    sample();
    check("t2_rd_lo_ack", b_ack, 1);
    check("t2_rvalid_hi", b_rvalid, 1);
    check("t2_rdata_hi", b_rdata, 16'h1234);
    tick();
    b_req = 1'b0;
    sample();
    check("t2_rvalid_lo", b_rvalid, 1);
    check("t2_rdata_lo", b_rdata, 16'h5678);
    check("t2_a_rvalid", a_rvalid, 0);
    tick();
    sample();
    check("t2_rvalid_end", b_rvalid, 0);

    // Test 3: round-robin after reset, both ports reading continuously.
    do_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 15'h0010;
    b_req = 1'b1; b_we = 1'b0; b_addr = 15'h4001;
    for (int i = 0; i < 6; i++) begin
      sample();
      check($sformatf("t3_a_ack_%0d", i), a_ack, (i % 2 == 0) ? 1 : 0);
      check($sformatf("t3_b_ack_%0d", i), b_ack, (i % 2 == 1) ? 1 : 0);
      if (i > 0) begin
        check($sformatf("t3_a_rvalid_%0d", i), a_rvalid, (i % 2 == 1) ? 1 : 0);
        check($sformatf("t3_b_rvalid_%0d", i), b_rvalid, (i % 2 == 0) ? 1 : 0);
      end
      if (i == 1) check("t3_a_rdata", a_rdata, 16'hBEEF);
      if (i == 2) check("t3_b_rdata", b_rdata, 16'h1234);
      tick();
    end
    a_req = 1'b0; b_req = 1'b0;
    sample();
    check("t3_last_b_rvalid", b_rvalid, 1);
    check("t3_last_b_rdata", b_rdata, 16'h1234);

    // Test 4: fixed priority, MAX_WAIT=3, B forced through on the 4th cycle.
    tick();
    a_we = 1'b0; b_we = 1'b0;
    f_a_req = 1'b1; f_b_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      check($sformatf("t4_a_ack_%0d", i), f_a_ack, exp_fb[i] ? 0 : 1);
      check($sformatf("t4_b_ack_%0d", i), f_b_ack, exp_fb[i] ? 1 : 0);
      check($sformatf("t4_wait_b_%0d", i), dut_fp.wait_b, exp_wait[i]);
      tick();
    end
    f_b_req = 1'b0;
    sample();
    check("t4_a_resumes", f_a_ack, 1);
    check("t4_wait_b_cleared", dut_fp.wait_b, 0);
    check("t4_b_rvalid", f_b_rvalid, 1);
    tick();
    f_a_req = 1'b0;

    // Test 5: reset asserted mid-cycle after a read ack.
    a_req = 1'b1; a_we = 1'b0; a_addr = 15'h0010;
    sample();
    check("t5_read_ack", a_ack, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_ack_in_reset", a_ack, 0);
    tick();
    reset_n = 1'b1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 15'h0001;
    sample();
    check("t5_dropped_rvalid", a_rvalid, 0);
    check("t5_conflict_a_ack", a_ack, 1);
    check("t5_conflict_b_ack", b_ack, 0);
    tick();
    a_req = 1'b0; b_req = 1'b0;
    sample();
    check("t5_post_rvalid", a_rvalid, 1);
    check("t5_post_rdata", a_rdata, 16'hBEEF);

    // Test 6: B writes 0x7FFF, A reads it on the very next cycle.
    tick();
    b_req = 1'b1; b_we = 1'b1; b_addr = 15'h7FFF; b_wdata = 16'hAAAA;
    sample();
    check("t6_b_wr_ack", b_ack, 1);
    tick();
    b_req = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 15'h7FFF;
    sample();
    check("t6_a_rd_ack", a_ack, 1);
    tick();
    a_req = 1'b0;
    sample();
    check("t6_a_rvalid", a_rvalid, 1);
    check("t6_a_rdata", a_rdata, 16'hAAAA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
